// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: combinational condition evaluation feeding a registered
// decision/redirect stage, plus saturating branch and taken statistics counters.
module branch_resolve_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [2:0]       cond,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [31:0]      target,
   output logic             out_valid,
   output logic             taken,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] branch_cnt
);

   typedef enum logic [2:0] {
      CondNone = 3'b000,
      CondBeq  = 3'b001,
      CondBne  = 3'b010,
      CondBlez = 3'b011,
      CondBgtz = 3'b100,
      CondBltz = 3'b101,
      CondBgez = 3'b110,
      CondRsvd = 3'b111
   } cond_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             out_valid_q, out_valid_d;
   logic             taken_q, taken_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

   logic  a_neg, a_zero, a_eq_b;
   logic  cond_true;
   logic  accept;
   logic  is_branch;
   logic  resolve_taken;
   cond_e cond_sel;

   // Signed compares against zero only need the sign bit and a zero detect.
   assign a_neg    = a[WIDTH-1];
   assign a_zero   = (a == '0);
   assign a_eq_b   = (a == b);
   assign cond_sel = cond_e'(cond);

   always_comb begin
      cond_true = 1'b0;
      unique case (cond_sel)
         CondNone: cond_true = 1'b0;
         CondBeq:  cond_true = a_eq_b;
         CondBne:  cond_true = !a_eq_b;
         CondBlez: cond_true = a_neg || a_zero;
         CondBgtz: cond_true = !a_neg && !a_zero;
         CondBltz: cond_true = a_neg;
         CondBgez: cond_true = !a_neg;
         CondRsvd: cond_true = 1'b0;
         default:  cond_true = 1'b0;
      endcase
   end

   assign accept        = in_valid && !stall && !flush;
   assign is_branch     = (cond_sel != CondNone) && (cond_sel != CondRsvd);
   // Reserved and none both force cond_true low, so taken implies is_branch.
   assign resolve_taken = cond_true && is_branch;

   always_comb begin
      out_valid_d   = out_valid_q;
      taken_d       = taken_q;
      redirect_pc_d = redirect_pc_q;
      if (flush) begin
         out_valid_d   = 1'b0;
         taken_d       = 1'b0;
         redirect_pc_d = '0;
      end else if (!stall) begin
         out_valid_d   = accept;
         taken_d       = accept && resolve_taken;
         redirect_pc_d = (accept && resolve_taken) ? target : 32'h0;
      end
   end

   // Both counters saturate at the same ceiling and taken only advances with a
   // branch, so taken_cnt can never overtake branch_cnt.
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (accept && is_branch && (branch_cnt_q != CntMax)) begin
         branch_cnt_d = branch_cnt_q + CntOne;
      end
      if (accept && resolve_taken && (taken_cnt_q != CntMax)) begin
         taken_cnt_d = taken_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         taken_q       <= 1'b0;
         redirect_pc_q <= '0;
         taken_cnt_q   <= '0;
         branch_cnt_q  <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         taken_q       <= taken_d;
         redirect_pc_q <= redirect_pc_d;
         taken_cnt_q   <= taken_cnt_d;
         branch_cnt_q  <= branch_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign taken       = taken_q;
   assign redirect_pc = redirect_pc_q;
   assign taken_cnt   = taken_cnt_q;
   assign branch_cnt  = branch_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second instance with 4-bit
// counters exercises saturation.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic [2:0]  cond;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] target;

   logic        out_valid, taken;
   logic [31:0] redirect_pc;
   logic [15:0] taken_cnt, branch_cnt;

   logic        out_valid4, taken4;
   logic [31:0] redirect_pc4;
   logic [3:0]  taken_cnt4, branch_cnt4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .cond(cond), .a(a), .b(b), .target(target),
      .out_valid(out_valid), .taken(taken), .redirect_pc(redirect_pc),
      .taken_cnt(taken_cnt), .branch_cnt(branch_cnt)
   );

   branch_resolve_unit #(.WIDTH(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .cond(cond), .a(a), .b(b), .target(target),
      .out_valid(out_valid4), .taken(taken4), .redirect_pc(redirect_pc4),
      .taken_cnt(taken_cnt4), .branch_cnt(branch_cnt4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic st, input logic fl, input logic [2:0] c,
                        input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] t);
      in_valid = iv;
      stall    = st;
      flush    = fl;
      cond     = c;
      a        = aa;
      b        = bb;
      target   = t;
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic ov, input logic tk,
                             input logic [31:0] pc, input int bc, input int tc);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
      check({tag, ".taken"}, 64'(taken), 64'(tk));
      check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(pc));
      check({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(bc));
      check({tag, ".taken_cnt"}, 64'(taken_cnt), 64'(tc));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd1, 32'h1000);
      step();
      step();
      expect_out("reset", 1'b0, 1'b0, 32'h0, 0, 0);
      check("reset.cnt4", 64'({taken_cnt4, branch_cnt4}), 64'h0);

      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd5, 32'd5, 32'h0040_0020);
      step();
      expect_out("beq_taken", 1'b1, 1'b1, 32'h0040_0020, 1, 1);

      drive(1'b1, 1'b0, 1'b0, 3'b010, 32'd5, 32'd5, 32'h0000_1234);
      step();
      expect_out("bne_not", 1'b1, 1'b0, 32'h0, 2, 1);

      drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'h0000_0100);
      step();
      expect_out("blez_neg", 1'b1, 1'b1, 32'h0000_0100, 3, 2);

      drive(1'b1, 1'b0, 1'b0, 3'b100, 32'h8000_0000, 32'd0, 32'h0000_0200);
      step();
      expect_out("bgtz_neg", 1'b1, 1'b0, 32'h0, 4, 2);

      drive(1'b1, 1'b0, 1'b0, 3'b110, 32'd0, 32'd7, 32'h0000_0300);
      step();
      expect_out("bgez_zero", 1'b1, 1'b1, 32'h0000_0300, 5, 3);

      drive(1'b1, 1'b0, 1'b0, 3'b101, 32'd0, 32'd7, 32'h0000_0400);
      step();
      expect_out("bltz_zero", 1'b1, 1'b0, 32'h0, 6, 3);

      drive(1'b1, 1'b0, 1'b0, 3'b100, 32'd1, 32'd0, 32'h0000_0500);
      step();
      expect_out("bgtz_pos", 1'b1, 1'b1, 32'h0000_0500, 7, 4);

      drive(1'b1, 1'b0, 1'b0, 3'b011, 32'd1, 32'd0, 32'h0000_0600);
      step();
      expect_out("blez_pos", 1'b1, 1'b0, 32'h0, 8, 4);

      drive(1'b1, 1'b0, 1'b0, 3'b111, 32'd0, 32'd0, 32'h0000_0700);
      step();
      expect_out("reserved", 1'b1, 1'b0, 32'h0, 8, 4);

      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0000_0800);
      step();
      expect_out("none", 1'b1, 1'b0, 32'h0, 8, 4);

      drive(1'b0, 1'b0, 1'b0, 3'b001, 32'd3, 32'd3, 32'h0000_0900);
      step();
      expect_out("idle", 1'b0, 1'b0, 32'h0, 8, 4);

      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_0000);
      step();
      expect_out("pre_stall", 1'b1, 1'b1, 32'hDEAD_0000, 9, 5);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 3'b001, 32'd1, 32'd1, 32'h0000_0055 + 32'(i));
         step();
         expect_out($sformatf("stall%0d", i), 1'b1, 1'b1, 32'hDEAD_0000, 9, 5);
      end

      drive(1'b1, 1'b1, 1'b1, 3'b001, 32'd1, 32'd1, 32'h0000_0066);
      step();
      expect_out("stall_flush", 1'b0, 1'b0, 32'h0, 9, 5);

      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd2, 32'd2, 32'h0000_0A00);
      step();
      expect_out("post_flush", 1'b1, 1'b1, 32'h0000_0A00, 10, 6);

      drive(1'b1, 1'b0, 1'b1, 3'b001, 32'd2, 32'd2, 32'h0000_0B00);
      step();
      expect_out("flush_only", 1'b0, 1'b0, 32'h0, 10, 6);

      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd4, 32'd4, 32'h0000_0C00);
      step();
      expect_out("pre_rst", 1'b1, 1'b1, 32'h0000_0C00, 11, 7);

      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd4, 32'd4, 32'h0000_0D00);
      step();
      expect_out("mid_rst", 1'b0, 1'b0, 32'h0, 0, 0);

      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd4, 32'd4, 32'h0000_0E00);
      step();
      expect_out("post_rst", 1'b1, 1'b1, 32'h0000_0E00, 1, 1);

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0);
      step();
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, 3'b001, 32'(i), 32'(i), 32'h0000_1000);
         step();
         if (i == 15 || i == 16) begin
            check($sformatf("sat4_taken@%0d", i), 64'(taken_cnt4), 64'd15);
            check($sformatf("sat4_branch@%0d", i), 64'(branch_cnt4), 64'd15);
         end
      end
      check("sat4_taken", 64'(taken_cnt4), 64'd15);
      check("sat4_branch", 64'(branch_cnt4), 64'd15);
      check("sat16_taken", 64'(taken_cnt), 64'd20);
      check("sat16_branch", 64'(branch_cnt), 64'd20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
